// File: rtl/param_counter_if.sv
// rtl/param_counter_if.sv - control/status bundle between a counter and its driver
//
// Carries everything except clk/reset.
//   start, en, load, load_val, limit, dir, wrap : controls, driven by master
//   ct, c_end, busy, done                        : status, driven by slave (the counter)

interface param_counter_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             dir;
    logic             wrap;
    logic [WIDTH-1:0] ct;
    logic             c_end;
    logic             busy;
    logic             done;

    modport master (
        output start, en, load, load_val, limit, dir, wrap,
        input  ct, c_end, busy, done
    );

    modport slave (
        input  start, en, load, load_val, limit, dir, wrap,
        output ct, c_end, busy, done
    );
endinterface

// File: rtl/param_counter.sv
// rtl/param_counter.sv - bounded up/down run counter with saturate or wrap at terminal
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset
//   bus    : param_counter_if.slave
//            start/load begin a run (load wins), en advances it one step per cycle,
//            limit/dir/wrap are captured only when a run begins,
//            ct is the registered count, c_end flags ct at terminal outside IDLE,
//            busy flags RUN, done is a one-cycle pulse after arriving at terminal.
//
// Terminal is lim_q counting up and 0 counting down; the start value is the
// opposite end. With wrap clear, arriving at terminal parks the counter in HOLD.

module param_counter #(
    parameter int WIDTH       = 5,
    parameter int DIR_UP_ONLY = 0
) (
    input  logic         clk,
    input  logic         reset,
    param_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] ct_q;
    logic [WIDTH-1:0] ct_n;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] lim_n;
    logic             dir_q;
    logic             dir_n;
    logic             wrap_q;
    logic             wrap_n;
    logic             done_q;
    logic             done_n;

    // Decodes of the captured run parameters.
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] step_ct;

    // Decodes of the incoming parameters, used on the edge a run begins.
    logic             dir_in;
    logic [WIDTH-1:0] seed_ct;
    logic [WIDTH-1:0] seed_term;
    logic             seed_at_term;

    always_comb begin
        dir_in    = (DIR_UP_ONLY != 0) ? 1'b0 : bus.dir;
        term_val  = dir_q ? '0 : lim_q;
        start_val = dir_q ? lim_q : '0;
        // Only used when ct != term_val, so it never leaves 0..lim_q.
        step_ct   = dir_q ? (ct_q - WIDTH'(1)) : (ct_q + WIDTH'(1));
    end

    always_comb begin
        seed_ct = '0;
        if (bus.load) begin
            // load_val is clamped so ct can never sit above the new bound.
            seed_ct = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
        end else begin
            seed_ct = dir_in ? bus.limit : '0;
        end
        seed_term    = dir_in ? '0 : bus.limit;
        seed_at_term = (seed_ct == seed_term);
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            ct_q   <= '0;
            lim_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            ct_q   <= ct_n;
            lim_q  <= lim_n;
            dir_q  <= dir_n;
            wrap_q <= wrap_n;
            done_q <= done_n;
        end
    end

    // Next-state and next-data logic; load and start share one path and
    // differ only in the seed value.
    always_comb begin
        state_n = state;
        ct_n    = ct_q;
        lim_n   = lim_q;
        dir_n   = dir_q;
        wrap_n  = wrap_q;
        done_n  = 1'b0;

        if (bus.load || bus.start) begin
            ct_n    = seed_ct;
            lim_n   = bus.limit;
            dir_n   = dir_in;
            wrap_n  = bus.wrap;
            done_n  = seed_at_term;
            state_n = (seed_at_term && !bus.wrap) ? HOLD : RUN;
        end else if (state == RUN && bus.en) begin
            if (ct_q == term_val) begin
                if (wrap_q) begin
                    ct_n   = start_val;
                    // Only a zero-length run lands back on terminal here.
                    done_n = (start_val == term_val);
                end else begin
                    state_n = HOLD;
                end
            end else begin
                ct_n = step_ct;
                if (step_ct == term_val) begin
                    done_n = 1'b1;
                    if (!wrap_q) begin
                        state_n = HOLD;
                    end
                end
            end
        end
    end

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        bus.ct    = ct_q;
        bus.done  = done_q;
        bus.busy  = (state == RUN);
        bus.c_end = (state != IDLE) && (ct_q == term_val);
    end

endmodule
